// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and alignment check for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane extraction for loads and lane merging for sub-word stores.
module lsu_align import lsu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic [15:0]     i_wdata,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    output logic [XLEN-1:0] o_rdata_fmt,
    output logic [XLEN-1:0] o_merged
);

    logic [4:0]      w_sh;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_ins;

    // Halfword accesses use addr[1] only as the lane select; byte accesses use addr[1:0].
    assign w_sh   = {i_addr_lo[1], i_addr_lo[0] & ~i_funct3[0], 3'b000};
    assign w_lane = i_mem_rdata >> w_sh;
    assign w_mask = (i_funct3[0] ? XLEN'(16'hFFFF) : XLEN'(8'hFF)) << w_sh;
    assign w_ins  = (i_funct3[0] ? XLEN'(i_wdata) : XLEN'(i_wdata[7:0])) << w_sh;

    always_comb begin
        o_rdata_fmt = (i_funct3 == F3_B)  ? {{(XLEN-8){w_lane[7]}}, w_lane[7:0]} :
                      (i_funct3 == F3_BU) ? {{(XLEN-8){1'b0}}, w_lane[7:0]} :
                      (i_funct3 == F3_H)  ? {{(XLEN-16){w_lane[15]}}, w_lane[15:0]} :
                      (i_funct3 == F3_HU) ? {{(XLEN-16){1'b0}}, w_lane[15:0]} :
                                            i_mem_rdata;
        o_merged    = (i_mem_rdata & ~w_mask) | w_ins;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit bridging a valid/ready request port to a word-only memory,
// doing read-modify-write for SB/SH and flagging misaligned/out-of-range accesses.
module lsu_mem_ctrl import lsu_pkg::*; #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * MEM_WORDS);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    logic            r_we;
    logic            r_err;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_merged;
    logic            w_bad_f3;
    logic            w_err;
    logic            w_word_st;
    logic            w_mem_phase;
    logic [XLEN-1:0] w_fmt;
    logic [XLEN-1:0] w_merged;

    assign w_bad_f3    = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                                : (req_funct3[1:0] == 2'b11 || req_funct3[2:1] == 2'b11);
    assign w_err       = w_bad_f3 || is_misaligned(req_funct3, req_addr[1:0]) || req_addr >= ADDR_LIMIT;
    assign w_word_st   = r_we && r_f3 == F3_W;
    assign w_mem_phase = r_state == ACCESS || r_state == WRITE;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_mem_rdata (mem_rdata),
        .i_wdata     (r_wdata[15:0]),
        .i_funct3    (r_f3),
        .i_addr_lo   (r_addr[1:0]),
        .o_rdata_fmt (w_fmt),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req_valid ? (w_err ? RESP : ACCESS) : IDLE;
            ACCESS:  w_next = (r_we && !w_word_st) ? WRITE : RESP;
            WRITE:   w_next = RESP;
            default: w_next = resp_ready ? IDLE : RESP;
        endcase
        req_ready  = r_state == IDLE;
        resp_valid = r_state == RESP;
        mem_read   = r_state == ACCESS && !w_word_st;
        mem_write  = (r_state == ACCESS && w_word_st) || r_state == WRITE;
        mem_addr   = w_mem_phase ? {r_addr[XLEN-1:2], 2'b00} : '0;
        mem_wdata  = (r_state == WRITE) ? r_merged : (r_state == ACCESS && w_word_st) ? r_wdata : '0;
    end

    // Load data is formatted as it is read; sub-word stores keep the merged word for WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_f3     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_merged <= '0;
        end else if (r_state == IDLE && req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_err   <= w_err;
            r_rdata <= '0;
        end else if (r_state == ACCESS) begin
            if (!r_we) r_rdata <= w_fmt;
            else       r_merged <= w_merged;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized checks of lsu_mem_ctrl against a byte-addressed
// reference memory, with a word-wide memory model answering the DUT.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [1024];
    logic [7:0]  ref_bytes [4096];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    logic [31:0] t_rd, t_waddr, t_wdat, e_rd;
    logic        t_er, t_both, e_er;
    int          t_lat, t_nrd, t_nwr;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.XLEN(32), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end

    task automatic set_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_idx = a[11:2];
        pl_data = d;
        for (int k = 0; k < 4; k++) ref_bytes[{a[11:2], 2'b00} + k] = 8'(d >> (8 * k));
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Reference: memory as bytes, access size 1/2/4 from funct3, extension from funct3[2].
    task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] r, output logic e);
        int sz;
        logic legal;
        sz = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        e = !legal || addr >= 32'd4096 || (addr % sz) != 0;
        r = '0;
        if (!e && !we) begin
            for (int k = 0; k < sz; k++) r = r | (32'(ref_bytes[int'(addr) + k]) << (8 * k));
            if (!f3[2] && sz < 4 && r[8 * sz - 1]) r = r | (32'hFFFF_FFFF << (8 * sz));
        end
        if (!e && we)
            for (int k = 0; k < sz; k++) ref_bytes[int'(addr) + k] = 8'(wdata >> (8 * k));
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t_lat = 1; t_nrd = 0; t_nwr = 0; t_both = 1'b0; t_waddr = '0; t_wdat = '0;
        while (!resp_valid && t_lat < 10) begin
            t_nrd += int'(mem_read);
            t_nwr += int'(mem_write);
            t_both |= mem_read & mem_write;
            if (mem_write) begin t_waddr = mem_addr; t_wdat = mem_wdata; end
            @(posedge clk); #1;
            t_lat++;
        end
        t_nrd += int'(mem_read);
        t_nwr += int'(mem_write);
        t_rd = resp_rdata;
        t_er = resp_err;
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, resp_err, mem_read, mem_write, req_ready} !== 5'b00001) begin
            errors++; $display("FAIL reset_ctrl got=%b want=%b", {resp_valid, resp_err, mem_read, mem_write, req_ready}, 5'b00001);
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data got=%h want=0", {resp_rdata, mem_addr, mem_wdata});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_lb_lbu();
        set_word(32'h80, 32'h1234_F678);
        do_req(1'b0, 3'b000, 32'h81, 32'h0);
        checks++; if (t_rd !== 32'hFFFF_FFF6) begin errors++; $display("FAIL lb_rdata got=%h want=%h", t_rd, 32'hFFFF_FFF6); end
        checks++; if (t_er !== 1'b0) begin errors++; $display("FAIL lb_err got=%b want=0", t_er); end
        checks++; if (t_lat != 2) begin errors++; $display("FAIL lb_latency got=%0d want=2", t_lat); end
        do_req(1'b0, 3'b100, 32'h81, 32'h0);
        checks++; if (t_rd !== 32'h0000_00F6) begin errors++; $display("FAIL lbu_rdata got=%h want=%h", t_rd, 32'h0000_00F6); end
        do_req(1'b0, 3'b000, 32'h8000_0001, 32'h0);
        checks++; if ({t_er, t_rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lb_range got=%b/%h want=1/0", t_er, t_rd); end
        checks++; if (t_lat != 1 || t_nrd != 0) begin errors++; $display("FAIL lb_range_timing got lat=%0d rd=%0d want 1/0", t_lat, t_nrd); end
    endtask

    task automatic test_sb_rmw();
        set_word(32'h40, 32'hAABB_CCDD);
        do_req(1'b1, 3'b000, 32'h42, 32'h0000_0011);
        checks++; if (t_nrd != 1 || t_nwr != 1) begin errors++; $display("FAIL sb_counts got rd=%0d wr=%0d want 1/1", t_nrd, t_nwr); end
        checks++; if (t_waddr !== 32'h40) begin errors++; $display("FAIL sb_waddr got=%h want=%h", t_waddr, 32'h40); end
        checks++; if (t_wdat !== 32'hAA11_CCDD) begin errors++; $display("FAIL sb_wdata got=%h want=%h", t_wdat, 32'hAA11_CCDD); end
        checks++; if (t_lat != 3 || t_er !== 1'b0) begin errors++; $display("FAIL sb_latency got=%0d err=%b want 3/0", t_lat, t_er); end
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        checks++; if (t_rd !== 32'hAA11_CCDD) begin errors++; $display("FAIL sb_readback got=%h want=%h", t_rd, 32'hAA11_CCDD); end
    endtask

    task automatic test_sh_lhu();
        set_word(32'h44, 32'hCAFE_BEEF);
        do_req(1'b1, 3'b001, 32'h46, 32'h1234_5678);
        checks++; if (t_wdat !== 32'h5678_BEEF) begin errors++; $display("FAIL sh_wdata got=%h want=%h", t_wdat, 32'h5678_BEEF); end
        do_req(1'b0, 3'b101, 32'h46, 32'h0);
        checks++; if (t_rd !== 32'h0000_5678) begin errors++; $display("FAIL lhu_rdata got=%h want=%h", t_rd, 32'h0000_5678); end
        do_req(1'b0, 3'b101, 32'h44, 32'h0);
        checks++; if (t_rd !== 32'h0000_BEEF) begin errors++; $display("FAIL sh_low_kept got=%h want=%h", t_rd, 32'h0000_BEEF); end
    endtask

    task automatic test_misaligned();
        do_req(1'b0, 3'b010, 32'h102, 32'h0);
        checks++; if ({t_er, t_rd} !== {1'b1, 32'h0} || t_lat != 1) begin errors++; $display("FAIL lw_misaligned got err=%b rd=%h lat=%0d want 1/0/1", t_er, t_rd, t_lat); end
        checks++; if (t_nrd != 0 || t_nwr != 0) begin errors++; $display("FAIL lw_misaligned_mem got rd=%0d wr=%0d want 0/0", t_nrd, t_nwr); end
        do_req(1'b1, 3'b001, 32'h101, 32'hFFFF);
        checks++; if (t_er !== 1'b1 || t_lat != 1) begin errors++; $display("FAIL sh_misaligned got err=%b lat=%0d want 1/1", t_er, t_lat); end
        checks++; if (t_nrd != 0 || t_nwr != 0) begin errors++; $display("FAIL sh_misaligned_mem got rd=%0d wr=%0d want 0/0", t_nrd, t_nwr); end
    endtask

    task automatic test_backpressure();
        int n;
        set_word(32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout got=%b want=1", resp_valid); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({resp_valid, req_ready, resp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b rd=%h want 1/0/deadbeef", c, resp_valid, req_ready, resp_rdata);
            end
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got=%b want=01", {resp_valid, req_ready}); end
    endtask

    task automatic test_reset_mid_write();
        set_word(32'h20, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'hAB;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_access_read got=%b want=1", mem_read); end
        @(posedge clk); #1;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_write_phase got=%b want=1", mem_write); end
        #1 rst = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_write_drop got=%b want=0", mem_write); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem[8] !== 32'h1122_3344) begin errors++; $display("FAIL rst_word_kept got=%h want=%h", mem[8], 32'h1122_3344); end
        checks++;
        if ({resp_valid, resp_err, mem_read, mem_write, req_ready, resp_rdata, mem_addr, mem_wdata} !== {5'b00001, 96'h0}) begin
            errors++; $display("FAIL rst_outputs got=%h want=%h", {resp_valid, resp_err, mem_read, mem_write, req_ready, resp_rdata, mem_addr, mem_wdata}, {5'b00001, 96'h0});
        end
        @(negedge clk); rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h20, 32'h0);
        checks++; if (t_rd !== 32'h1122_3344) begin errors++; $display("FAIL rst_readback got=%h want=%h", t_rd, 32'h1122_3344); end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int          x_lat, x_rd, x_wr;
        for (int w = 0; w < 64; w++) set_word(32'(w * 4), $urandom);
        for (int i = 0; i < 300; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4096, 9000)) : 32'($urandom_range(0, 255));
            wdata = $urandom;
            ref_op(we, f3, addr, wdata, e_rd, e_er);
            x_lat = e_er ? 1 : (we && f3 != 3'd2) ? 3 : 2;
            x_rd  = (e_er || (we && f3 == 3'd2)) ? 0 : 1;
            x_wr  = (!e_er && we) ? 1 : 0;
            do_req(we, f3, addr, wdata);
            checks++;
            if ({t_er, t_rd} !== {e_er, e_rd}) begin
                errors++; $display("FAIL rand_resp i=%0d we=%b f3=%0d a=%h got=%b/%h want=%b/%h", i, we, f3, addr, t_er, t_rd, e_er, e_rd);
            end
            checks++;
            if (t_lat != x_lat || t_nrd != x_rd || t_nwr != x_wr || t_both !== 1'b0) begin
                errors++; $display("FAIL rand_timing i=%0d got lat=%0d rd=%0d wr=%0d both=%b want %0d/%0d/%0d/0", i, t_lat, t_nrd, t_nwr, t_both, x_lat, x_rd, x_wr);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = '0;
        for (int k = 0; k < 4096; k++) ref_bytes[k] = '0;
        test_reset();
        test_lb_lbu();
        test_sb_rmw();
        test_sh_lhu();
        test_misaligned();
        test_backpressure();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
